mac_rx_frame_reader: RTL and testbench

Read-side controller for the MAC receive path. It detects a completed frame in the receive buffer, acknowledges it, sequences the byte-read handshake (`read_en` / `mac_rx_data_out` / `read_complete`), and filters on destination MAC. Accepted frames are forwarded as an 8-bit valid/ready stream with `m_tlast`; rejected frames are drained and discarded. Ok/drop statistics are kept.

---
 rtl/mac_rx_frame_reader_if.sv | 28 ++
 rtl/mac_rx_frame_reader.sv | 236 +++++++++++++++++++++++
 tb/tb_mac_rx_frame_reader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_frame_reader_if.sv
// mac_rx_frame_reader_if
//   Bundles the receive-buffer read handshake and the 8-bit output stream
//   of the MAC receive frame reader.
//   Receive buffer side : frame_received, frame_received_ack, read_en,
//                         mac_rx_data_out, read_complete
//   Output stream side  : m_tdata, m_tvalid, m_tlast, m_tready
//   master = the frame reader; slave = the buffer/sink environment.
interface mac_rx_frame_reader_if;
    logic       frame_received;
    logic       frame_received_ack;
    logic       read_en;
    logic [7:0] mac_rx_data_out;
    logic       read_complete;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tlast;
    logic       m_tready;

    modport master (
        input  frame_received, mac_rx_data_out, read_complete, m_tready,
        output frame_received_ack, read_en, m_tdata, m_tvalid, m_tlast
    );

    modport slave (
        output frame_received, mac_rx_data_out, read_complete, m_tready,
        input  frame_received_ack, read_en, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/mac_rx_frame_reader.sv
// mac_rx_frame_reader
//   Takes completed frames out of the MAC receive buffer, filters them on
//   destination MAC and forwards accepted frames as an 8-bit valid/ready
//   stream (m_tlast on the final byte). Rejected frames are read out and
//   discarded. Saturating ok/drop frame counters.
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   enable          : allows a new frame to start (never aborts one)
//   promisc         : accept every destination
//   station_mac     : own address, [47:40] first on the wire
//   bus             : buffer handshake + output stream (master modport)
//   frames_ok       : accepted frames fully forwarded
//   frames_dropped  : rejected or runt frames
module mac_rx_frame_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         promisc,
    input  logic [47:0]                  station_mac,
    mac_rx_frame_reader_if.master        bus,
    output logic [15:0]                  frames_ok,
    output logic [15:0]                  frames_dropped
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    // Room for the staged byte and the byte still in flight from the buffer.
    localparam logic [AW:0]     RD_THRESH = (AW+1)'(FIFO_DEPTH - 3);
    localparam logic [47:0]     BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_HDR, S_DECIDE, S_EMIT, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] hdr_sel(input logic [47:0] h, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = h[47:40];
            3'd1:    b = h[39:32];
            3'd2:    b = h[31:24];
            3'd3:    b = h[23:16];
            3'd4:    b = h[15:8];
            default: b = h[7:0];
        endcase
        return b;
    endfunction

    state_t         state;
    logic           ack_q;
    logic           read_en_q;
    logic [10:0]    rd_idx;
    logic           accepted;
    logic [2:0]     emit_idx;
    logic [47:0]    hdr;

    // staging register: holds the newest byte until we know whether it is last
    logic           stg_vld;
    logic           stg_last;
    logic [7:0]     stg_data;

    // capture path: one-cycle-delayed copy of the request path
    logic           vld_p1;
    logic [10:0]    idx_p1;

    logic [8:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    fifo_count;
    logic [AW:0]    count_next;

    logic           fifo_empty;
    logic           fifo_full;
    logic           pop;
    logic           can_push;
    logic           flush_last;
    logic           emit_push;
    logic           cap_push;
    logic           push;
    logic [8:0]     push_word;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign pop        = !fifo_empty && bus.m_tready;
    assign can_push   = !fifo_full || pop;
    assign flush_last = stg_vld && stg_last;
    // a pending tlast byte from the previous frame must leave before new header bytes
    assign emit_push  = (state == S_EMIT) && !stg_vld && can_push;
    assign cap_push   = (state == S_STREAM) && vld_p1;

    always_comb begin
        push      = 1'b0;
        push_word = '0;
        if (flush_last) begin
            push      = can_push;
            push_word = {1'b1, stg_data};
        end else if (emit_push) begin
            push      = 1'b1;
            push_word = {1'b0, hdr_sel(hdr, emit_idx)};
        end else if (cap_push) begin
            push      = 1'b1;
            push_word = {1'b0, stg_data};
        end
    end

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + 1'b1;
            2'b01:   count_next = fifo_count - 1'b1;
            default: count_next = fifo_count;
        endcase
    end

    assign bus.frame_received_ack = ack_q;
    assign bus.read_en            = read_en_q;
    assign bus.m_tvalid           = !fifo_empty;
    assign bus.m_tdata            = fifo_empty ? 8'h00 : mem[rd_ptr][7:0];
    assign bus.m_tlast            = fifo_empty ? 1'b0  : mem[rd_ptr][8];

    // ---- control: FSM, request path, FIFO pointers, counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            ack_q          <= 1'b0;
            read_en_q      <= 1'b0;
            rd_idx         <= '0;
            accepted       <= 1'b0;
            emit_idx       <= '0;
            stg_vld        <= 1'b0;
            stg_last       <= 1'b0;
            vld_p1         <= 1'b0;
            idx_p1         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            ack_q      <= 1'b0;
            vld_p1     <= read_en_q;
            idx_p1     <= rd_idx;
            fifo_count <= count_next;
            if (read_en_q) rd_idx <= rd_idx + 11'd1;
            if (push)      wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            if (flush_last && can_push) begin
                stg_vld  <= 1'b0;
                stg_last <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (enable && bus.frame_received) begin
                        ack_q <= 1'b1;
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    rd_idx    <= '0;
                    read_en_q <= 1'b1;
                    accepted  <= 1'b0;
                    state     <= S_HDR;
                end
                S_HDR: begin
                    if (read_en_q && bus.read_complete) begin
                        // runt: frame ended inside the destination address
                        read_en_q      <= 1'b0;
                        frames_dropped <= sat_inc(frames_dropped);
                        state          <= S_DONE;
                    end else begin
                        if (read_en_q && rd_idx == 11'd5) read_en_q <= 1'b0;
                        if (vld_p1 && idx_p1 == 11'd5)    state     <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (promisc || hdr == station_mac || hdr == BCAST) begin
                        accepted <= 1'b1;
                        emit_idx <= '0;
                        state    <= S_EMIT;
                    end else begin
                        frames_dropped <= sat_inc(frames_dropped);
                        read_en_q      <= 1'b1;
                        state          <= S_DRAIN;
                    end
                end
                S_EMIT: begin
                    if (emit_push) begin
                        emit_idx <= emit_idx + 3'd1;
                        if (emit_idx == 3'd4) begin
                            stg_vld   <= 1'b1;
                            stg_last  <= 1'b0;
                            read_en_q <= (count_next <= RD_THRESH);
                            state     <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (read_en_q && bus.read_complete) begin
                        // the staged byte is the final one; it leaves with tlast
                        read_en_q <= 1'b0;
                        stg_last  <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        read_en_q <= (count_next <= RD_THRESH);
                    end
                end
                S_DRAIN: begin
                    if (bus.read_complete) begin
                        read_en_q <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (accepted) frames_ok <= sat_inc(frames_ok);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- data: header shift, staging register, FIFO storage ----
    always_ff @(posedge clk) begin
        if (state == S_HDR && vld_p1) hdr <= {hdr[39:0], bus.mac_rx_data_out};
        if (emit_push && emit_idx == 3'd4) stg_data <= hdr[7:0];
        else if (cap_push)                 stg_data <= bus.mac_rx_data_out;
        if (push) mem[wr_ptr] <= push_word;
    end

endmodule

// File: tb/tb_mac_rx_frame_reader.sv
module tb_mac_rx_frame_reader;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        promisc;
    logic [47:0] station_mac;
    logic [15:0] frames_ok;
    logic [15:0] frames_dropped;

    mac_rx_frame_reader_if bus();

    mac_rx_frame_reader #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .enable(enable), .promisc(promisc),
        .station_mac(station_mac), .bus(bus),
        .frames_ok(frames_ok), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // receive buffer model
    logic [7:0] frm_mem [0:3][0:79];
    int         frm_len [0:3];
    int         loaded, taken, idx, cur, prev_idx, cyc;
    bit         busy, rc_last, prev_req;
    logic [7:0] pl_buf [0:63];

    // sink model and observations
    int         ready_mode;
    bit         prev_stall;
    logic [8:0] prev_word;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];
    int         acks, thr_viol, stall_viol, tvalid_cnt, req_cnt;
    int         ack_cyc, rd_cyc, tv_cyc;

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (prev_stall && (!bus.m_tvalid || {bus.m_tlast, bus.m_tdata} !== prev_word)) stall_viol++;
        case (ready_mode)
            0:       bus.m_tready = 1'b1;
            1:       bus.m_tready = !bus.m_tready;
            default: bus.m_tready = 1'b0;
        endcase
        if (bus.m_tvalid) begin
            tvalid_cnt++;
            if (tv_cyc < 0) tv_cyc = cyc;
        end
        if (bus.m_tvalid && bus.m_tready) got.push_back({bus.m_tlast, bus.m_tdata});
        prev_stall = !rst && bus.m_tvalid && !bus.m_tready;
        prev_word  = {bus.m_tlast, bus.m_tdata};
        if (bus.read_en && int'(dut.fifo_count) > D - 3) thr_viol++;
        if (bus.read_en && rd_cyc < 0) rd_cyc = cyc;
        // byte for the request issued in the previous cycle
        bus.mac_rx_data_out = prev_req ? ((prev_idx < frm_len[cur]) ? frm_mem[cur][prev_idx] : 8'hEE) : 8'h5A;
        if (rc_last) busy = 1'b0;
        rc_last = 1'b0;
        if (bus.frame_received_ack) begin
            acks++;
            if (ack_cyc < 0) ack_cyc = cyc;
            cur = taken % 4;
            taken++;
            busy = 1'b1;
            idx = 0;
        end
        prev_req = bus.read_en;
        prev_idx = idx;
        bus.read_complete = bus.read_en && (idx == frm_len[cur]);
        if (bus.read_en) begin
            req_cnt++;
            idx++;
        end
        if (bus.read_complete) rc_last = 1'b1;
        bus.frame_received = (taken < loaded) && !busy;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic model_clear();
        taken = loaded; busy = 0; rc_last = 0; prev_req = 0; idx = 0;
        got.delete(); exp_q.delete();
        acks = 0; thr_viol = 0; stall_viol = 0; tvalid_cnt = 0; req_cnt = 0;
        ack_cyc = -1; rd_cyc = -1; tv_cyc = -1; prev_stall = 0;
        bus.frame_received = 1'b0;
        bus.read_complete  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        model_clear();
    endtask

    // frame = dest(6) type(2) payload(plen from pl_buf)
    task automatic load_frame(input logic [47:0] dest, input logic [15:0] typ,
                              input int plen, input bit accept);
        int s;
        s = loaded % 4;
        for (int i = 0; i < 6; i++) frm_mem[s][i] = dest[47-8*i -: 8];
        frm_mem[s][6] = typ[15:8];
        frm_mem[s][7] = typ[7:0];
        for (int i = 0; i < plen; i++) frm_mem[s][8+i] = pl_buf[i];
        frm_len[s] = plen + 8;
        if (accept)
            for (int i = 0; i < plen + 8; i++) exp_q.push_back({(i == plen + 7), frm_mem[s][i]});
        loaded++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(2);
        checks++; if (bus.read_en !== 1'b0) begin failures++; $display("FAIL rst_read_en got=%0b exp=0", bus.read_en); end
        checks++; if (bus.frame_received_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", bus.frame_received_ack); end
        checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%0b exp=0", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 8'h00) begin failures++; $display("FAIL rst_tdata got=%0h exp=0", bus.m_tdata); end
        checks++; if (bus.m_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%0b exp=0", bus.m_tlast); end
        checks++; if (frames_ok !== 16'd0) begin failures++; $display("FAIL rst_ok got=%0d exp=0", frames_ok); end
        checks++; if (frames_dropped !== 16'd0) begin failures++; $display("FAIL rst_dropped got=%0d exp=0", frames_dropped); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_unicast();
        do_reset();
        station_mac = 48'h02_00_00_00_00_01;
        promisc = 1'b0;
        enable = 1'b0;
        pl_buf[0] = 8'h11; pl_buf[1] = 8'h22; pl_buf[2] = 8'h33; pl_buf[3] = 8'h44;
        load_frame(48'h02_00_00_00_00_01, 16'h0800, 4, 1'b1);
        run(10);
        checks++; if (acks !== 0) begin failures++; $display("FAIL uc_enable_gate acks=%0d exp=0", acks); end
        enable = 1'b1;
        run(40);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL uc_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (got.size() != 12) begin failures++; $display("FAIL uc_count got=%0d exp=12", got.size()); end
        checks++; if (acks != 1) begin failures++; $display("FAIL uc_acks got=%0d exp=1", acks); end
        checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL uc_ok got=%0d exp=1", frames_ok); end
        checks++; if (frames_dropped !== 16'd0) begin failures++; $display("FAIL uc_dropped got=%0d exp=0", frames_dropped); end
        checks++; if (rd_cyc - ack_cyc != 1) begin failures++; $display("FAIL uc_rd_latency got=%0d exp=1", rd_cyc - ack_cyc); end
        checks++; if (tv_cyc - ack_cyc < 9) begin failures++; $display("FAIL uc_tvalid_latency got=%0d exp>=9", tv_cyc - ack_cyc); end
        checks++; if (req_cnt != 13) begin failures++; $display("FAIL uc_requests got=%0d exp=13", req_cnt); end
    endtask

    task automatic test_filter();
        do_reset();
        promisc = 1'b0;
        pl_buf[0] = 8'hA1; pl_buf[1] = 8'hA2; pl_buf[2] = 8'hA3; pl_buf[3] = 8'hA4;
        load_frame(48'h02_00_00_00_00_99, 16'h0800, 4, 1'b0);
        run(40);
        checks++; if (tvalid_cnt != 0) begin failures++; $display("FAIL drop_tvalid got=%0d exp=0", tvalid_cnt); end
        checks++; if (frames_dropped !== 16'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", frames_dropped); end
        checks++; if (frames_ok !== 16'd0) begin failures++; $display("FAIL drop_ok got=%0d exp=0", frames_ok); end
        checks++; if (req_cnt != 13) begin failures++; $display("FAIL drop_requests got=%0d exp=13", req_cnt); end
        checks++; if (acks != 1) begin failures++; $display("FAIL drop_acks got=%0d exp=1", acks); end
        promisc = 1'b1;
        load_frame(48'h02_00_00_00_00_99, 16'h0800, 4, 1'b1);
        run(40);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL promisc_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL promisc_ok got=%0d exp=1", frames_ok); end
        checks++; if (frames_dropped !== 16'd1) begin failures++; $display("FAIL promisc_dropped got=%0d exp=1", frames_dropped); end
        promisc = 1'b0;
    endtask

    task automatic test_broadcast();
        do_reset();
        pl_buf[0] = 8'hDE; pl_buf[1] = 8'hAD;
        load_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0806, 2, 1'b1);
        run(40);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bcast_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (got.size() != 10) begin failures++; $display("FAIL bcast_count got=%0d exp=10", got.size()); end
        checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL bcast_ok got=%0d exp=1", frames_ok); end
    endtask

    task automatic test_stall();
        do_reset();
        ready_mode = 1;
        for (int i = 0; i < 60; i++) pl_buf[i] = 8'(i * 3 + 7);
        load_frame(48'h02_00_00_00_00_01, 16'h86DD, 60, 1'b1);
        run(400);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (got.size() != 68) begin failures++; $display("FAIL stall_count got=%0d exp=68", got.size()); end
        checks++; if (thr_viol != 0) begin failures++; $display("FAIL stall_threshold violations=%0d exp=0", thr_viol); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_hold violations=%0d exp=0", stall_viol); end
        checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL stall_ok got=%0d exp=1", frames_ok); end
        ready_mode = 0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        pl_buf[0] = 8'h01; pl_buf[1] = 8'h02;
        load_frame(48'h02_00_00_00_00_01, 16'h0800, 2, 1'b1);
        pl_buf[0] = 8'hAA; pl_buf[1] = 8'hBB; pl_buf[2] = 8'hCC;
        load_frame(48'hFF_FF_FF_FF_FF_FF, 16'h0800, 3, 1'b1);
        run(80);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (got.size() != 21) begin failures++; $display("FAIL b2b_count got=%0d exp=21", got.size()); end
        checks++; if (acks != 2) begin failures++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
        checks++; if (frames_ok !== 16'd2) begin failures++; $display("FAIL b2b_ok got=%0d exp=2", frames_ok); end
    endtask

    task automatic test_reset_mid();
        // counters still hold the back-to-back results here
        ready_mode = 1;
        for (int i = 0; i < 20; i++) pl_buf[i] = 8'(8'h80 + i);
        load_frame(48'h02_00_00_00_00_01, 16'h0800, 20, 1'b0);
        run(22);
        rst = 1'b1;
        tick();
        checks++; if (bus.read_en !== 1'b0) begin failures++; $display("FAIL mid_read_en got=%0b exp=0", bus.read_en); end
        checks++; if (bus.m_tvalid !== 1'b0) begin failures++; $display("FAIL mid_tvalid got=%0b exp=0", bus.m_tvalid); end
        checks++; if (bus.m_tdata !== 8'h00) begin failures++; $display("FAIL mid_tdata got=%0h exp=0", bus.m_tdata); end
        checks++; if (bus.m_tlast !== 1'b0) begin failures++; $display("FAIL mid_tlast got=%0b exp=0", bus.m_tlast); end
        checks++; if (bus.frame_received_ack !== 1'b0) begin failures++; $display("FAIL mid_ack got=%0b exp=0", bus.frame_received_ack); end
        checks++; if (frames_ok !== 16'd0) begin failures++; $display("FAIL mid_ok got=%0d exp=0", frames_ok); end
        checks++; if (frames_dropped !== 16'd0) begin failures++; $display("FAIL mid_dropped got=%0d exp=0", frames_dropped); end
        rst = 1'b0;
        ready_mode = 0;
        model_clear();
        pl_buf[0] = 8'h55; pl_buf[1] = 8'h66; pl_buf[2] = 8'h77;
        load_frame(48'h02_00_00_00_00_01, 16'h0800, 3, 1'b1);
        run(40);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL after_rst_byte%0d got=%0h exp=%0h", i, (i < got.size()) ? got[i] : 9'h1FF, exp_q[i]);
            end
        end
        checks++; if (got.size() != 11) begin failures++; $display("FAIL after_rst_count got=%0d exp=11", got.size()); end
        checks++; if (frames_ok !== 16'd1) begin failures++; $display("FAIL after_rst_ok got=%0d exp=1", frames_ok); end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        promisc = 1'b0;
        station_mac = 48'h02_00_00_00_00_01;
        bus.frame_received = 1'b0;
        bus.read_complete = 1'b0;
        bus.mac_rx_data_out = 8'h00;
        bus.m_tready = 1'b1;
        ready_mode = 0;
        loaded = 0;
        taken = 0;
        cur = 0;
        cyc = 0;
        prev_word = '0;
        model_clear();

        test_reset();
        test_unicast();
        test_filter();
        test_broadcast();
        test_stall();
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
